// File: rtl/alu_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_arbiter
// Purpose  : Two-requester round-robin front end sequencing the shared
//            invert / +1-add ALU datapath; optional ALU_ARB_FIXED_PRI_EN
//            selects fixed priority (requester 0 wins ties).
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_arbiter #(
    parameter int BUS_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0_valid,
    output logic                 req0_ready,
    input  logic [1:0]           req0_op,
    input  logic [BUS_WIDTH-1:0] req0_a,
    input  logic [BUS_WIDTH-1:0] req0_b,
    input  logic                 req1_valid,
    output logic                 req1_ready,
    input  logic [1:0]           req1_op,
    input  logic [BUS_WIDTH-1:0] req1_a,
    input  logic [BUS_WIDTH-1:0] req1_b,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic                 rsp_id,
    output logic [BUS_WIDTH-1:0] rsp_y,
    output logic                 rsp_carry
);

    localparam logic [1:0] C_OP_NOTA = 2'b00;
    localparam logic [1:0] C_OP_SUB  = 2'b11;

    localparam logic [1:0] C_ST_IDLE = 2'd0;
    localparam logic [1:0] C_ST_INV  = 2'd1;
    localparam logic [1:0] C_ST_ADD  = 2'd2;
    localparam logic [1:0] C_ST_RESP = 2'd3;

    logic [1:0]           r_state;
    logic [1:0]           r_op;
    logic [BUS_WIDTH-1:0] r_a;
    logic [BUS_WIDTH-1:0] r_b;
    logic [BUS_WIDTH-1:0] r_tmp;
    logic                 r_carry;
    logic                 r_id;
    logic                 r_rsp_valid;

    logic                 w_tie_id;
    logic                 w_grant_id;
    logic                 w_accept;
    logic [BUS_WIDTH:0]   w_addend;
    logic [BUS_WIDTH:0]   w_sum;

`ifdef ALU_ARB_FIXED_PRI_EN
    assign w_tie_id = 1'b0;
`else
    logic r_last_id;

    // Requester 0 must win the first tie after reset, hence the reset value 1.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_last_id <= 1'b1;
        end else if (w_accept) begin
            r_last_id <= w_grant_id;
        end
    end

    assign w_tie_id = ~r_last_id;
`endif

    always_comb begin
        w_grant_id = 1'b0;
        if (req0_valid && req1_valid) begin
            w_grant_id = w_tie_id;
        end else if (req1_valid) begin
            w_grant_id = 1'b1;
        end
        w_accept = (r_state == C_ST_IDLE) && (req0_valid || req1_valid);
    end

    assign req0_ready = w_accept && !w_grant_id;
    assign req1_ready = w_accept &&  w_grant_id;

    // NEGB adds only the +1; SUB folds A into the same adder.
    assign w_addend = (r_op == C_OP_SUB) ? {1'b0, r_a} : '0;
    assign w_sum    = {1'b0, r_tmp} + w_addend + (BUS_WIDTH+1)'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= C_ST_IDLE;
            r_op        <= 2'b00;
            r_a         <= '0;
            r_b         <= '0;
            r_tmp       <= '0;
            r_carry     <= 1'b0;
            r_id        <= 1'b0;
            r_rsp_valid <= 1'b0;
        end else begin
            case (r_state)
                C_ST_IDLE: begin
                    if (w_accept) begin
                        r_id    <= w_grant_id;
                        r_op    <= w_grant_id ? req1_op : req0_op;
                        r_a     <= w_grant_id ? req1_a  : req0_a;
                        r_b     <= w_grant_id ? req1_b  : req0_b;
                        r_state <= C_ST_INV;
                    end
                end
                C_ST_INV: begin
                    r_tmp   <= (r_op == C_OP_NOTA) ? ~r_a : ~r_b;
                    r_carry <= 1'b0;
                    if (r_op[1]) begin
                        r_state <= C_ST_ADD;
                    end else begin
                        r_state     <= C_ST_RESP;
                        r_rsp_valid <= 1'b1;
                    end
                end
                C_ST_ADD: begin
                    {r_carry, r_tmp} <= w_sum;
                    r_state          <= C_ST_RESP;
                    r_rsp_valid      <= 1'b1;
                end
                C_ST_RESP: begin
                    if (rsp_ready) begin
                        r_state     <= C_ST_IDLE;
                        r_rsp_valid <= 1'b0;
                    end
                end
                default: begin
                    r_state <= C_ST_IDLE;
                end
            endcase
        end
    end

    assign rsp_valid = r_rsp_valid;
    assign rsp_id    = r_id;
    assign rsp_y     = r_tmp;
    assign rsp_carry = r_carry;

endmodule
`default_nettype wire

// File: tb/tb_alu_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_op_arbiter
// Purpose  : Self-checking bench for alu_op_arbiter (vector table, corner
//            sequences, randomized ops against an arithmetic reference model).
// Revision : 1.0 - initial release
// ============================================================================
module tb_alu_op_arbiter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst;
    logic         req0_valid, req0_ready, req1_valid, req1_ready;
    logic [1:0]   req0_op, req1_op;
    logic [W-1:0] req0_a, req0_b, req1_a, req1_b;
    logic         rsp_valid, rsp_ready, rsp_id, rsp_carry;
    logic [W-1:0] rsp_y;

    int n_checks = 0;
    int n_fail   = 0;

    alu_op_arbiter #(.BUS_WIDTH(W)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_a(req0_a), .req0_b(req0_b),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_a(req1_a), .req1_b(req1_b),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id),
        .rsp_y(rsp_y), .rsp_carry(rsp_carry)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         id;
        logic [1:0] op;
        logic [7:0] a;
        logic [7:0] b;
        logic [7:0] y;
        logic       c;
        int         lat;
    } vec_t;

    typedef struct {
        bit         id;
        logic [7:0] y;
        logic       c;
    } exp_t;

    // Result from the opcode definitions using integer arithmetic: {carry, y}.
    function automatic logic [8:0] ref_model(input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        int ia = int'(a);
        int ib = int'(b);
        case (op)
            2'd0:    return {1'b0, 8'(255 - ia)};
            2'd1:    return {1'b0, 8'(255 - ib)};
            2'd2:    return {(ib == 0), 8'((256 - ib) % 256)};
            default: return {(ia >= ib), 8'((ia - ib + 256) % 256)};
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #2;
    endtask

    task automatic drive(input bit id, input logic v, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b);
        if (id) begin
            req1_valid = v; req1_op = op; req1_a = a; req1_b = b;
        end else begin
            req0_valid = v; req0_op = op; req0_a = a; req0_b = b;
        end
    endtask

    task automatic run_op(input bit id, input logic [1:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int hold, output int lat, output logic [7:0] y, output logic c, output logic rid);
        int n = 0;
        drive(id, 1'b1, op, a, b);
        #1;
        while (!(id ? req1_ready : req0_ready) && n < 20) begin
            step; #1; n++;
        end
        chk("accept_wait", 32'(n < 20), 32'd1);
        step;
        drive(id, 1'b0, op, a, b);
        lat = 1;
        #1;
        while (!rsp_valid && lat < 20) begin
            step; #1; lat++;
        end
        y = rsp_y; c = rsp_carry; rid = rsp_id;
        repeat (hold) step;
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
    endtask

    task automatic wait_rsp(output bit seen);
        int n = 0;
        #1;
        while (!rsp_valid && n < 20) begin
            step; #1; n++;
        end
        seen = rsp_valid;
    endtask

    initial begin
        vec_t         vecs[7];
        exp_t         expq[$];
        int           lat;
        logic [7:0]   y;
        logic         c, rid;
        bit           seen;
        logic [8:0]   m;
        int           cnt0, cnt1, ngrant;
        bit           exp_order[8];

        vecs[0] = '{id:1'b0, op:2'd3, a:8'h05, b:8'h03, y:8'h02, c:1'b1, lat:3};
        vecs[1] = '{id:1'b1, op:2'd3, a:8'h03, b:8'h05, y:8'hFE, c:1'b0, lat:3};
        vecs[2] = '{id:1'b1, op:2'd2, a:8'h33, b:8'h00, y:8'h00, c:1'b1, lat:3};
        vecs[3] = '{id:1'b1, op:2'd2, a:8'h00, b:8'h80, y:8'h80, c:1'b0, lat:3};
        vecs[4] = '{id:1'b0, op:2'd0, a:8'hA5, b:8'h11, y:8'h5A, c:1'b0, lat:2};
        vecs[5] = '{id:1'b0, op:2'd1, a:8'h00, b:8'h0F, y:8'hF0, c:1'b0, lat:2};
        vecs[6] = '{id:1'b1, op:2'd3, a:8'h7C, b:8'h7C, y:8'h00, c:1'b1, lat:3};

        rst = 1'b1; rsp_ready = 1'b0;
        drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);

        // Reset state and first-cycle ready
        repeat (3) step;
        rst = 1'b0;
        #1;
        chk("reset_outputs", {rsp_valid, rsp_id, rsp_carry, rsp_y}, 32'd0);
        req0_valid = 1'b1;
        #1;
        chk("first_idle_req0_ready", {req0_ready, req1_ready}, 32'b10);
        req0_valid = 1'b0;

        // Directed vector table
        for (int i = 0; i < 7; i++) begin
            run_op(vecs[i].id, vecs[i].op, vecs[i].a, vecs[i].b, (i % 2) + 1, lat, y, c, rid);
            chk($sformatf("vec%0d_y", i),       32'(y),   32'(vecs[i].y));
            chk($sformatf("vec%0d_carry", i),   32'(c),   32'(vecs[i].c));
            chk($sformatf("vec%0d_id", i),      32'(rid), 32'(vecs[i].id));
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vecs[i].lat));
        end

        // Tie arbitration: both requesters valid continuously, 4 ops each
`ifdef ALU_ARB_FIXED_PRI_EN
        exp_order = '{0, 0, 0, 0, 1, 1, 1, 1};
`else
        exp_order = '{0, 1, 0, 1, 0, 1, 0, 1};
`endif
        cnt0 = 0; cnt1 = 0; ngrant = 0;
        drive(1'b0, 1'b1, 2'($urandom % 4), 8'($urandom), 8'($urandom));
        drive(1'b1, 1'b1, 2'($urandom % 4), 8'($urandom), 8'($urandom));
        rsp_ready = 1'b1;
        for (int cyc = 0; cyc < 200 && (cnt0 < 4 || cnt1 < 4 || expq.size() > 0); cyc++) begin
            bit     g_valid;
            bit     g;
            #1;
            if (rsp_valid) begin
                if (expq.size() == 0) begin
                    chk("tie_unexpected_rsp", 32'd1, 32'd0);
                end else begin
                    chk("tie_rsp", {rsp_id, rsp_carry, rsp_y}, {expq[0].id, expq[0].c, expq[0].y});
                    void'(expq.pop_front());
                end
            end
            g_valid = req0_ready || req1_ready;
            g = req1_ready;
            if (g_valid) begin
                chk($sformatf("tie_grant%0d", ngrant), 32'(g), 32'(exp_order[ngrant % 8]));
                ngrant++;
                m = g ? ref_model(req1_op, req1_a, req1_b) : ref_model(req0_op, req0_a, req0_b);
                expq.push_back('{id:g, y:m[7:0], c:m[8]});
            end
            step;
            if (g_valid && !g) begin
                cnt0++;
                drive(1'b0, cnt0 < 4, 2'($urandom % 4), 8'($urandom), 8'($urandom));
            end else if (g_valid && g) begin
                cnt1++;
                drive(1'b1, cnt1 < 4, 2'($urandom % 4), 8'($urandom), 8'($urandom));
            end
        end
        chk("tie_all_done", {8'(cnt0), 8'(cnt1), 8'(expq.size())}, {8'd4, 8'd4, 8'd0});
        rsp_ready = 1'b0;
        step;

        // Stall in RESP with rsp_ready low
        drive(1'b0, 1'b1, 2'd3, 8'h09, 8'h04);
        #1;
        chk("stall_accept_ready", 32'(req0_ready), 32'd1);
        step;
        drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        drive(1'b1, 1'b1, 2'd0, 8'h3C, 8'h00);
        wait_rsp(seen);
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall_hold%0d", k), {rsp_valid, rsp_id, rsp_carry, rsp_y, req0_ready, req1_ready},
                {1'b1, 1'b0, 1'b1, 8'h05, 1'b0, 1'b0});
            step; #1;
        end
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;
        #1;
        chk("stall_release_next_accept", {rsp_valid, req1_ready}, 32'b01);
        step;
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
        wait_rsp(seen);
        chk("stall_next_rsp", {seen, rsp_id, rsp_carry, rsp_y}, {1'b1, 1'b1, 1'b0, 8'hC3});
        rsp_ready = 1'b1;
        step;
        rsp_ready = 1'b0;

        // Reset during ADD of a SUB drops the op
        drive(1'b1, 1'b1, 2'd3, 8'h10, 8'h01);
        #1;
        chk("rst_mid_accept", 32'(req1_ready), 32'd1);
        step;
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
        step;
        rst = 1'b1;
        step;
        rst = 1'b0;
        #1;
        chk("rst_mid_outputs", {rsp_valid, rsp_id, rsp_carry, rsp_y}, 32'd0);
        drive(1'b0, 1'b1, 2'd0, 8'h11, 8'h00);
        drive(1'b1, 1'b1, 2'd1, 8'h00, 8'h22);
        #1;
        chk("rst_mid_tie_grant", {req0_ready, req1_ready}, 32'b10);
        step;
        drive(1'b0, 1'b0, 2'd0, 8'h00, 8'h00);
        rsp_ready = 1'b1;
        wait_rsp(seen);
        chk("rst_mid_first_rsp", {seen, rsp_id, rsp_carry, rsp_y}, {1'b1, 1'b0, 1'b0, 8'hEE});
        step;
        wait_rsp(seen);
        chk("rst_mid_second_rsp", {seen, rsp_id, rsp_carry, rsp_y}, {1'b1, 1'b1, 1'b0, 8'hDD});
        step;
        drive(1'b1, 1'b0, 2'd0, 8'h00, 8'h00);
        rsp_ready = 1'b0;
        step;

        // Randomized single ops against the reference model
        for (int i = 0; i < 40; i++) begin
            bit         rid_in;
            logic [1:0] op;
            logic [7:0] a, b;
            rid_in = 1'($urandom);
            op     = 2'($urandom);
            a      = 8'($urandom);
            b      = 8'($urandom);
            if (i % 8 == 0) b = a;
            run_op(rid_in, op, a, b, int'($urandom_range(0, 3)), lat, y, c, rid);
            m = ref_model(op, a, b);
            chk($sformatf("rand%0d_result", i), {rid, c, y}, {rid_in, m[8], m[7:0]});
            chk($sformatf("rand%0d_latency", i), 32'(lat), op[1] ? 32'd3 : 32'd2);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
